// File: rtl/f1_frame_loader_pkg.sv
// Shared types and defaults for the f1 frame loader: FSM encoding, RAM write payload, widths.
package f1_frame_loader_pkg;

    localparam int unsigned NUM_PIXELS_DEF  = 1024;
    localparam int unsigned TIMEOUT_CYC_DEF = 1048576;
    localparam int unsigned WORD_STRIDE_DEF = 4;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BE_W        = 4;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned RES_VALUE_W = 16;
    localparam int unsigned RES_INDEX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } fl_state_t;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } f1_wr_t;

endpackage

// File: rtl/f1_frame_loader_byte_packer.sv
// Packs accepted pixels 4-per-word and issues registered f1 RAM writes, flushing partial words on demand.
module f1_byte_packer
    import f1_frame_loader_pkg::*;
#(
    parameter int unsigned WORD_STRIDE = WORD_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic             sof,
    input  logic             flush,
    input  logic [PIX_W-1:0] pix_data,
    output f1_wr_t           wr,
    output logic             wr_ena
);

    logic [1:0]        lane_q;
    logic [WORD_W-1:0] pack_q;
    logic [ADDR_W-1:0] addr_q;

    logic [1:0]        lane_c;
    logic [WORD_W-1:0] word_c;
    logic [ADDR_W-1:0] addr_c;
    logic [BE_W-1:0]   be_c;
    logic              emit_c;

    // First pixel of a frame restarts at lane 0 / address 0 regardless of leftovers.
    always_comb begin
        lane_c = sof ? 2'd0 : lane_q;
        addr_c = sof ? '0 : addr_q;
        word_c = (sof ? '0 : pack_q) | (WORD_W'(pix_data) << {lane_c, 3'b000});
        be_c   = BE_W'((5'd2 << lane_c) - 5'd1);
        emit_c = accept & ((lane_c == 2'd3) | flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            pack_q <= '0;
            addr_q <= '0;
            wr     <= '0;
            wr_ena <= 1'b0;
        end else begin
            wr_ena <= 1'b0;
            wr.be  <= '0;
            if (accept) begin
                if (emit_c) begin
                    wr.be   <= be_c;
                    wr.addr <= addr_c;
                    wr.data <= word_c;
                    wr_ena  <= 1'b1;
                    addr_q  <= addr_c + ADDR_W'(WORD_STRIDE);
                    lane_q  <= '0;
                    pack_q  <= '0;
                end else begin
                    lane_q <= lane_c + 2'd1;
                    pack_q <= word_c;
                    addr_q <= addr_c;
                end
            end
        end
    end

endmodule

// File: rtl/f1_frame_loader.sv
// Loads a streamed pixel frame into f1 RAM, kicks the CNN core and holds its result for the host.
module f1_frame_loader
    import f1_frame_loader_pkg::*;
#(
    parameter int unsigned NUM_PIXELS  = NUM_PIXELS_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned WORD_STRIDE = WORD_STRIDE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic [3:0]  f1_wr_en,
    output logic [31:0] f1_waddr,
    output logic [31:0] f1_wdata,
    output logic        ena,
    output logic        acc_start,
    input  logic        acc_done,
    input  logic [15:0] acc_class_value,
    input  logic [3:0]  acc_class_index,
    output logic        res_valid,
    output logic [15:0] res_value,
    output logic [3:0]  res_index,
    input  logic        res_ack,
    output logic        err
);

    localparam int unsigned PCNT_W = $clog2(NUM_PIXELS);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC) + 1;

    fl_state_t         state_q, state_d;
    logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              err_d;
    logic              capture_c;

    logic              accept_c;
    logic              sof_c;
    logic [PCNT_W-1:0] pix_idx_c;
    logic              last_idx_c;
    logic              flush_c;

    f1_wr_t            wr;

    always_comb begin
        accept_c   = pix_valid & pix_ready;
        sof_c      = (state_q == ST_IDLE);
        pix_idx_c  = sof_c ? '0 : pix_cnt_q;
        last_idx_c = (pix_idx_c == PCNT_W'(NUM_PIXELS - 1));
        flush_c    = pix_last & ~last_idx_c;
    end

    // Next-state logic; err clears on the first pixel of a frame unless that pixel re-flags it.
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        tcnt_d    = tcnt_q;
        err_d     = err;
        capture_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept_c) begin
                    if (sof_c) err_d = 1'b0;
                    pix_cnt_d = pix_idx_c + PCNT_W'(1);
                    if (last_idx_c) begin
                        state_d = ST_START;
                        if (!pix_last) err_d = 1'b1;
                    end else if (pix_last) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_START: begin
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (acc_done) begin
                    capture_c = 1'b1;
                    state_d   = ST_RESULT;
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_RESULT: begin
                if (res_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pix_cnt_q <= '0;
            tcnt_q    <= '0;
            err       <= 1'b0;
            pix_ready <= 1'b0;
            acc_start <= 1'b0;
            res_valid <= 1'b0;
            res_value <= '0;
            res_index <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            tcnt_q    <= tcnt_d;
            err       <= err_d;
            pix_ready <= (state_d == ST_IDLE) | (state_d == ST_LOAD);
            acc_start <= (state_q == ST_START);
            res_valid <= (state_d == ST_RESULT);
            if (capture_c) begin
                res_value <= acc_class_value;
                res_index <= acc_class_index;
            end
        end
    end

    f1_byte_packer #(
        .WORD_STRIDE (WORD_STRIDE)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept_c),
        .sof      (sof_c),
        .flush    (flush_c),
        .pix_data (pix_data),
        .wr       (wr),
        .wr_ena   (ena)
    );

    assign f1_wr_en = wr.be;
    assign f1_waddr = wr.addr;
    assign f1_wdata = wr.data;

endmodule

// File: tb/tb_f1_frame_loader.sv
// Directed bench for f1_frame_loader: full/partial frames, gaps, result handshake, timeout, mid-run resets.
module tb_f1_frame_loader;

    localparam int unsigned NPIX = 1024;
    localparam int unsigned TOUT = 64;
    localparam int unsigned NWORD = NPIX / 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid, pix_last, pix_ready;
    logic [7:0]  pix_data;
    logic [3:0]  f1_wr_en;
    logic [31:0] f1_waddr, f1_wdata;
    logic        ena, acc_start, acc_done;
    logic [15:0] acc_class_value;
    logic [3:0]  acc_class_index;
    logic        res_valid;
    logic [15:0] res_value;
    logic [3:0]  res_index;
    logic        res_ack, err;

    f1_frame_loader #(
        .NUM_PIXELS  (NPIX),
        .TIMEOUT_CYC (TOUT),
        .WORD_STRIDE (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_last        (pix_last),
        .pix_ready       (pix_ready),
        .f1_wr_en        (f1_wr_en),
        .f1_waddr        (f1_waddr),
        .f1_wdata        (f1_wdata),
        .ena             (ena),
        .acc_start       (acc_start),
        .acc_done        (acc_done),
        .acc_class_value (acc_class_value),
        .acc_class_index (acc_class_index),
        .res_valid       (res_valid),
        .res_value       (res_value),
        .res_index       (res_index),
        .res_ack         (res_ack),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write/start monitor, sampled shortly after the active edge.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          start_cnt = 0;
    int          last_wr_cyc = 0;
    int          start_cyc = 0;
    int          frame_id = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic [31:0] mem [NWORD];
    int          stamp [NWORD];
    logic [31:0] log_addr [$];

    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (ena) begin
            wr_cnt++;
            last_waddr  = f1_waddr;
            last_wdata  = f1_wdata;
            last_be     = f1_wr_en;
            last_wr_cyc = cyc;
            log_addr.push_back(f1_waddr);
            if (f1_wr_en == 4'hF && f1_waddr < 32'(NPIX)) begin
                mem[f1_waddr[9:2]]   = f1_wdata;
                stamp[f1_waddr[9:2]] = frame_id;
            end
        end
        if (acc_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    task automatic send_pix(input logic [7:0] d, input logic last, input bit gaps);
        int g;
        if (gaps && $urandom_range(0, 9) < 3) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        g = 0;
        while (!pix_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!pix_ready) chk("ready_timeout", 32'(pix_ready), 32'd1);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int last_at, input bit gaps);
        for (int i = lo; i <= hi; i++) send_pix(8'(i), (i == last_at), gaps);
    endtask

    task automatic wait_start(input int base);
        int g = 0;
        while (start_cnt == base && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (start_cnt == base) chk("start_timeout", 32'(start_cnt - base), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int id);
        int bad = 0;
        logic [31:0] e;
        for (int w = 0; w < int'(NWORD); w++) begin
            e = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            if (stamp[w] != id || mem[w] !== e) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_wr"}, {ena, acc_start, res_valid, err, f1_wr_en}, 32'd0);
        chk({tag, "_waddr"}, f1_waddr, 32'd0);
        chk({tag, "_wdata"}, f1_wdata, 32'd0);
        chk({tag, "_res"}, {res_value, res_index}, 32'd0);
    endtask

    int b_wr, b_st;

    initial begin
        for (int w = 0; w < int'(NWORD); w++) begin
            mem[w]   = '0;
            stamp[w] = -1;
        end
        rst_n = 1'b0;
        pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
        acc_done = 1'b0; acc_class_value = '0; acc_class_index = '0; res_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // acc_done while idle is ignored
        acc_done = 1'b1; acc_class_value = 16'hDEAD; acc_class_index = 4'h3;
        @(negedge clk);
        acc_done = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", {15'd0, res_valid, res_value}, 32'd0);

        // Full gap-free frame
        frame_id = 1; b_wr = wr_cnt; b_st = start_cnt;
        send_range(0, NPIX - 1, NPIX - 1, 1'b0);
        wait_start(b_st);
        chk("a_wr_count", 32'(wr_cnt - b_wr), 32'(NWORD));
        chk("a_last_addr", last_waddr, 32'd1020);
        chk("a_start_lat", 32'(start_cyc - last_wr_cyc), 32'd1);
        chk("a_word1", mem[1], 32'h07060504);
        check_frame("a_frame", 1);
        chk("a_err", 32'(err), 32'd0);

        // Pixels offered during WAIT/RESULT must not be consumed
        b_wr = wr_cnt;
        pix_valid = 1'b1; pix_data = 8'hAA;
        repeat (49) @(negedge clk);
        chk("wait_ready", 32'(pix_ready), 32'd0);
        acc_done = 1'b1; acc_class_value = 16'h1234; acc_class_index = 4'd7;
        @(negedge clk);
        acc_done = 1'b0; acc_class_value = 16'h5555; acc_class_index = 4'd1;
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_value", 32'(res_value), 32'h1234);
        chk("res_index", 32'(res_index), 32'd7);
        repeat (10) @(negedge clk);
        chk("res_hold", {11'd0, res_valid, res_value, res_index}, {11'd0, 1'b1, 16'h1234, 4'd7});
        chk("res_ready", 32'(pix_ready), 32'd0);
        chk("no_consume", 32'(wr_cnt - b_wr), 32'd0);
        pix_valid = 1'b0;
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        chk("ack_clears", {30'd0, res_valid, pix_ready}, 32'd1);
        chk("ack_value_kept", 32'(res_value), 32'h1234);
        chk("ack_start_once", 32'(start_cnt - b_st), 32'd1);

        // Early pix_last on pixel 5: partial flush, error, no start
        b_wr = wr_cnt; b_st = start_cnt;
        send_range(0, 5, 5, 1'b0);
        chk("early_wr_count", 32'(wr_cnt - b_wr), 32'd2);
        chk("early_addr", last_waddr, 32'd4);
        chk("early_be", 32'(last_be), 32'h3);
        chk("early_data", last_wdata, 32'h00000504);
        chk("early_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        chk("early_no_start", 32'(start_cnt - b_st), 32'd0);
        chk("early_ready", 32'(pix_ready), 32'd1);

        // Gapped frame; first pixel clears err; then let WAIT time out
        frame_id = 2; b_wr = wr_cnt; b_st = start_cnt;
        send_pix(8'd0, 1'b0, 1'b1);
        chk("err_cleared", 32'(err), 32'd0);
        send_range(1, NPIX - 1, NPIX - 1, 1'b1);
        wait_start(b_st);
        chk("gap_wr_count", 32'(wr_cnt - b_wr), 32'(NWORD));
        check_frame("gap_frame", 2);
        repeat (TOUT - 1) @(negedge clk);
        chk("tout_before", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("tout_err", 32'(err), 32'd1);
        chk("tout_res_valid", 32'(res_valid), 32'd0);
        chk("tout_idle", 32'(pix_ready), 32'd1);

        // acc_done on the timeout-limit cycle: done wins, no error
        frame_id = 3; b_st = start_cnt;
        send_range(0, NPIX - 1, NPIX - 1, 1'b0);
        wait_start(b_st);
        repeat (TOUT - 1) @(negedge clk);
        acc_done = 1'b1; acc_class_value = 16'hBEEF; acc_class_index = 4'hA;
        @(negedge clk);
        acc_done = 1'b0;
        chk("edge_res", {11'd0, res_valid, res_value, res_index}, {11'd0, 1'b1, 16'hBEEF, 4'hA});
        chk("edge_no_err", 32'(err), 32'd0);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;

        // Reset during LOAD at pixel 300
        b_st = start_cnt;
        send_range(0, 299, -1, 1'b0);
        chk("pre_rst_addr", last_waddr, 32'd296);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_load");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_wr = wr_cnt;
        repeat (20) @(negedge clk);
        chk("rst_load_quiet", 32'(wr_cnt - b_wr + start_cnt - b_st), 32'd0);

        // Reset during WAIT
        send_range(0, NPIX - 1, NPIX - 1, 1'b0);
        wait_start(b_st);
        b_st = start_cnt;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_wr = wr_cnt;
        repeat (20) @(negedge clk);
        chk("rst_wait_quiet", 32'(wr_cnt - b_wr + start_cnt - b_st + 32'(res_valid)), 32'd0);

        // Fresh frame after reset loads from address 0
        frame_id = 4; b_wr = wr_cnt;
        send_range(0, NPIX - 1, NPIX - 1, 1'b0);
        wait_start(b_st);
        chk("post_rst_first_addr", log_addr[b_wr], 32'd0);
        check_frame("post_rst_frame", 4);
        chk("post_rst_start", 32'(start_cnt - b_st), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
